period_meter: RTL
=================

// Module: period_meter
// PURPOSE
//  Measures a slow clock-like input (e.g. a divider output or external strobe).
//  It counts fast-clock cycles between consecutive rising edges (period) and while the input is high (high time).
//  It is the receive-side counterpart of the clock divider: the divider turns a count into a frequency, and this block turns a frequency back into a count.
//  Used for self-check of divided clocks and for measuring external tick sources.
// PARAMETERS
//  CNT_W    32           width of period/high counters and outputs
//  TIMEOUT  150000000    cycles without a rising edge before timeout; must be < 2**CNT_W
// PORTS
//  clk        input   1      system clock; only clock in the block
//  rst        input   1      synchronous, active-high reset
//  en         input   1      1 = measure; 0 = return to IDLE
//  sig_in     input   1      asynchronous signal under measurement
//  period     output  CNT_W  last measured period, clk cycles rise-to-rise
//  high_time  output  CNT_W  last measured high time, clk cycles
//  valid      output  1      1-cycle pulse when period/high_time update
//  timeout    output  1      sticky: no rising edge within TIMEOUT cycles
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): state=IDLE; sync regs, cnt, hi_cnt, period, high_time, valid and timeout all 0.
//  Sync: s1<=sig_in; s2<=s1; s3<=s2; rise=s2&~s3 (combinational).
//   Input-to-rise latency is a fixed 2-3 clk, so edge-to-edge distances are exact.
//  FSM states: IDLE, ARM, MEAS.
//   IDLE: cnt=hi_cnt=0; en=1 -> ARM.
//   ARM: wait for rise. On rise: cnt<=1, hi_cnt<=1 -> MEAS.
//   MEAS, on rise: period<=cnt; high_time<=hi_cnt; valid<=1; timeout<=0;
//    cnt<=1; hi_cnt<=1; stay in MEAS.
//   MEAS, no rise: cnt<=cnt+1; hi_cnt<=hi_cnt+s2.
//   MEAS, no rise and cnt==TIMEOUT: timeout<=1; cnt<=0; hi_cnt<=0 -> ARM.
//    The next rise in ARM starts a fresh measurement and does not update period.
//  Result: an input with rising edges P clk apart and high for H clk gives period=P, high_time=H.
//  Timing: valid is registered and asserts the cycle after rise is seen. period/high_time are stable from that cycle until the next update.
//  en=0 in any state -> IDLE next cycle.
//   period and high_time hold; valid=0; timeout<=0.
//   en has priority over rise and timeout in the same cycle.
//  First rising edge after ARM only arms the counters and produces no valid.
//   The first valid comes one full period later.
//  cnt never exceeds TIMEOUT, so there is no wrap-around.
//  rise and cnt==TIMEOUT in the same cycle: rise wins (period=TIMEOUT, valid=1, no timeout).
//  rst mid-measurement: abort everything, back to the reset values above.
//  Glitches shorter than 1 clk may be missed. Inputs faster than clk/2 are unsupported, with undefined results.
// TESTING
//  1 sig_in = clkdivider #(n=2) output, en=1 -> valid every 4 clk; period=4, high_time=2; 1st valid 1 period after arming.
//  2 clkdivider #(n=5) -> period=10, high_time=5, stable over 20 consecutive valids.
//  3 TIMEOUT=20, sig_in stuck 0 after one rise -> timeout=1 exactly 20 clk after that rise, state ARM.
//    Then resume n=3 -> 1st valid period=6, timeout clears with that valid.
//  4 rst=1 for 1 clk mid-period -> next cycle all outputs 0, IDLE.
//    Measurement restarts and 1st valid comes 2 periods after release.
//  5 en=0 for 3 clk during MEAS -> no valid, period holds old value.
//    After en=1, the first rise only arms; the next rise gives the correct period.
//  6 Hand-driven sig_in: high 7 clk, low 13 clk -> period=20, high_time=7.

Source files
------------

// File: rtl/period_meter.sv
// period_meter: measures rise-to-rise period and high time of a slow input, in clk cycles.
// A sticky timeout flags the absence of rising edges for TIMEOUT cycles.
module period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 150000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    state_t           r_state, w_next;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt, r_hi_cnt, r_period, r_high_time;
    logic             r_valid, r_timeout;
    logic             w_rise, w_to;
    assign w_rise    = r_s2 & ~r_s3;
    assign w_to      = r_cnt == CNT_W'(TIMEOUT);
    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign timeout   = r_timeout;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = ARM;
            ARM:     w_next = w_rise ? MEAS : ARM;
            MEAS:    w_next = (!w_rise && w_to) ? ARM : MEAS;
            default: w_next = IDLE;
        endcase
        if (!en) w_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_s1, r_s2, r_s3} <= '0;
            r_cnt              <= '0;
            r_hi_cnt           <= '0;
            r_period           <= '0;
            r_high_time        <= '0;
            r_valid            <= 1'b0;
            r_timeout          <= 1'b0;
        end else begin
            r_s1    <= sig_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_valid <= 1'b0;
            // disable outranks both a rise and a timeout in the same cycle
            if (!en) begin
                r_cnt     <= '0;
                r_hi_cnt  <= '0;
                r_timeout <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt    <= '0;
                        r_hi_cnt <= '0;
                    end
                    ARM: begin
                        if (w_rise) begin
                            r_cnt    <= CNT_W'(1);
                            r_hi_cnt <= CNT_W'(1);
                        end
                    end
                    MEAS: begin
                        if (w_rise) begin
                            r_period    <= r_cnt;
                            r_high_time <= r_hi_cnt;
                            r_valid     <= 1'b1;
                            r_timeout   <= 1'b0;
                            r_cnt       <= CNT_W'(1);
                            r_hi_cnt    <= CNT_W'(1);
                        end else if (w_to) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
                            r_hi_cnt  <= '0;
                        end else begin
                            r_cnt    <= r_cnt + CNT_W'(1);
                            r_hi_cnt <= r_hi_cnt + CNT_W'(r_s2);
                        end
                    end
                    default: begin
                        r_cnt    <= '0;
                        r_hi_cnt <= '0;
                    end
                endcase
            end
        end
    end
endmodule
